// File: rtl/writeback_stage_if.sv
// Writeback stage port bundle: upstream instruction fields plus
// register-file write, forwarding, trap and instret observation.
interface writeback_stage_if #(
  parameter int XLEN    = 32,
  parameter int RF_ADDR = 5
);
  logic               in_valid_i;
  logic               in_ready_o;
  logic [XLEN-1:0]    alu_result_i;
  logic [XLEN-1:0]    pc_plus4_i;
  logic [RF_ADDR-1:0] rd_addr_i;
  logic               reg_write_i;
  logic [1:0]         wb_sel_i;
  logic [2:0]         load_funct3_i;
  logic [XLEN-1:0]    data_read_i;
  logic               stall_i;
  logic               flush_i;
  logic               rf_we_o;
  logic [RF_ADDR-1:0] rf_waddr_o;
  logic [XLEN-1:0]    rf_wdata_o;
  logic [1:0]         fwd_valid_o;
  logic [2*RF_ADDR-1:0] fwd_rd_o;
  logic [2*XLEN-1:0]  fwd_data_o;
  logic               trap_o;
  logic [XLEN-1:0]    trap_addr_o;
  logic [XLEN-1:0]    instret_o;

  modport master (
    output in_valid_i, alu_result_i, pc_plus4_i,
    output rd_addr_i, reg_write_i, wb_sel_i,
    output load_funct3_i, data_read_i,
    output stall_i, flush_i,
    input  in_ready_o, rf_we_o, rf_waddr_o,
    input  rf_wdata_o, fwd_valid_o, fwd_rd_o,
    input  fwd_data_o, trap_o, trap_addr_o,
    input  instret_o
  );

  modport slave (
    input  in_valid_i, alu_result_i, pc_plus4_i,
    input  rd_addr_i, reg_write_i, wb_sel_i,
    input  load_funct3_i, data_read_i,
    input  stall_i, flush_i,
    output in_ready_o, rf_we_o, rf_waddr_o,
    output rf_wdata_o, fwd_valid_o, fwd_rd_o,
    output fwd_data_o, trap_o, trap_addr_o,
    output instret_o
  );
endinterface

// File: rtl/writeback_stage.sv
// Two-register writeback stage: load format, source mux, forwarding, instret.
// Define WB_MISALIGN_TRAP_EN to trap misaligned loads instead of masking.
module writeback_stage #(
  parameter int XLEN    = 32,
  parameter int RF_ADDR = 5
) (
  input  logic           clk_i,
  input  logic           reset_i,
  writeback_stage_if.slave wb
);

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    alu;
    logic [XLEN-1:0]    pc4;
    logic [RF_ADDR-1:0] rd;
    logic               reg_write;
    logic [1:0]         wb_sel;
    logic [2:0]         funct3;
  } s1_t;

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic [RF_ADDR-1:0] rd;
    logic [XLEN-1:0]    data;
  } s2_t;

  s1_t             s1_q;
  s2_t             s2_q;
  logic            hold_valid_q;
  logic [XLEN-1:0] hold_data_q;
  logic [XLEN-1:0] instret_q;

  logic            accept;
  logic            s1_load;
  logic            is_byte;
  logic            is_half;
  logic            is_word;
  logic            trap_hit;
  logic [1:0]      lane;
  logic [XLEN-1:0] mem_data;
  logic [7:0]      byte_val;
  logic [15:0]     half_val;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] result;

  assign accept  = wb.in_valid_i & ~wb.stall_i & ~wb.flush_i;
  assign s1_load = s1_q.valid & (s1_q.wb_sel == SEL_LOAD);

  // Read data is only on the bus for one cycle; a stall replays it from hold.
  assign mem_data = hold_valid_q ? hold_data_q : wb.data_read_i;

  assign is_byte = (s1_q.funct3 == F3_LB) | (s1_q.funct3 == F3_LBU);
  assign is_half = (s1_q.funct3 == F3_LH) | (s1_q.funct3 == F3_LHU);
  assign is_word = ~is_byte & ~is_half;

`ifdef WB_MISALIGN_TRAP_EN
  logic            misalign;
  logic            trap_q;
  logic [XLEN-1:0] trap_addr_q;

  assign lane     = s1_q.alu[1:0];
  assign misalign = (is_half & s1_q.alu[0]) |
                    (is_word & (|s1_q.alu[1:0]));
  assign trap_hit = s1_load & misalign;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      trap_q <= ~wb.stall_i & ~wb.flush_i & trap_hit;
      if (~wb.stall_i & ~wb.flush_i & trap_hit)
        trap_addr_q <= s1_q.alu;
    end
  end

  assign wb.trap_o      = trap_q;
  assign wb.trap_addr_o = trap_addr_q;
`else
  // Untrapped misaligned loads fall back to the naturally aligned lane.
  assign lane = is_byte ? s1_q.alu[1:0] :
                is_half ? {s1_q.alu[1], 1'b0} : 2'b00;
  assign trap_hit       = 1'b0;
  assign wb.trap_o      = 1'b0;
  assign wb.trap_addr_o = '0;
`endif

  always_comb begin
    byte_val = 8'h00;
    unique case (lane)
      2'd0: byte_val = mem_data[7:0];
      2'd1: byte_val = mem_data[15:8];
      2'd2: byte_val = mem_data[23:16];
      2'd3: byte_val = mem_data[31:24];
    endcase
    half_val = lane[1] ? mem_data[31:16] : mem_data[15:0];

    load_val = mem_data;
    unique case (1'b1)
      (s1_q.funct3 == F3_LB):
        load_val = {{(XLEN-8){byte_val[7]}}, byte_val};
      (s1_q.funct3 == F3_LBU):
        load_val = {{(XLEN-8){1'b0}}, byte_val};
      (s1_q.funct3 == F3_LH):
        load_val = {{(XLEN-16){half_val[15]}}, half_val};
      (s1_q.funct3 == F3_LHU):
        load_val = {{(XLEN-16){1'b0}}, half_val};
      default:
        load_val = mem_data;
    endcase

    result = s1_q.alu;
    unique case (s1_q.wb_sel)
      SEL_LOAD: result = load_val;
      SEL_PC4:  result = s1_q.pc4;
      default:  result = s1_q.alu;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q         <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      if (wb.flush_i) begin
        s1_q.valid <= 1'b0;
      end else if (~wb.stall_i) begin
        s1_q.valid <= accept;
        if (accept) begin
          s1_q.alu       <= wb.alu_result_i;
          s1_q.pc4       <= wb.pc_plus4_i;
          s1_q.rd        <= wb.rd_addr_i;
          s1_q.reg_write <= wb.reg_write_i;
          s1_q.wb_sel    <= wb.wb_sel_i;
          s1_q.funct3    <= wb.load_funct3_i;
        end
      end

      if (wb.flush_i | ~wb.stall_i) begin
        hold_valid_q <= 1'b0;
      end else if (s1_load & ~hold_valid_q) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= wb.data_read_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s2_q <= '0;
    end else if (~wb.stall_i) begin
      s2_q.valid     <= s1_q.valid & ~wb.flush_i;
      s2_q.reg_write <= s1_q.reg_write & ~trap_hit;
      s2_q.rd        <= s1_q.rd;
      s2_q.data      <= result;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      instret_q <= '0;
    else if (~wb.stall_i & s2_q.valid)
      instret_q <= instret_q + 1'b1;
  end

  assign wb.in_ready_o = ~wb.stall_i;
  assign wb.rf_we_o    = s2_q.valid & s2_q.reg_write & (|s2_q.rd);
  assign wb.rf_waddr_o = s2_q.rd;
  assign wb.rf_wdata_o = s2_q.data;
  assign wb.instret_o  = instret_q;

  assign wb.fwd_valid_o = {
    wb.rf_we_o,
    s1_q.valid & s1_q.reg_write & (|s1_q.rd)
  };
  assign wb.fwd_rd_o   = {s2_q.rd, s1_q.rd};
  assign wb.fwd_data_o = {s2_q.data, result};

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected writes queued at drive
// time, popped when the register-file port retires a write.
module tb_writeback_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  writeback_stage_if wbif ();

  writeback_stage dut (
    .clk_i   (clk),
    .reset_i (reset),
    .wb      (wbif)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          wr_count = 0;
  int          trap_count = 0;
  logic [31:0] pend_data = '0;
  logic [31:0] exp_instret = '0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] sel,
                                        input logic [31:0] alu,
                                        input logic [31:0] pc4,
                                        input logic [2:0] f3,
                                        input logic [31:0] m);
    logic [31:0] sh;
    logic [31:0] r;
    sh = m >> (8 * alu[1:0]);
    case (f3)
      3'b000:  r = 32'($signed(sh[7:0]));
      3'b100:  r = {24'h0, sh[7:0]};
      3'b001:  r = alu[1] ? 32'($signed(m[31:16]))
                          : 32'($signed(m[15:0]));
      3'b101:  r = alu[1] ? {16'h0, m[31:16]} : {16'h0, m[15:0]};
      default: r = m;
    endcase
    if (sel == 2'b01)      return r;
    else if (sel == 2'b10) return pc4;
    else                   return alu;
  endfunction

  function automatic logic traps(input logic [1:0] sel,
                                 input logic [2:0] f3,
                                 input logic [31:0] alu);
`ifdef WB_MISALIGN_TRAP_EN
    if (sel != 2'b01) return 1'b0;
    if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
    if (f3 == 3'b001 || f3 == 3'b101) return alu[0];
    return alu[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input logic v, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [4:0] rd,
                       input logic rw, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] m,
                       input logic fl, input logic st);
    exp_t e;
    @(posedge clk);
    #1;
    wbif.data_read_i   = pend_data;
    pend_data          = m;
    wbif.in_valid_i    = v;
    wbif.alu_result_i  = alu;
    wbif.pc_plus4_i    = pc4;
    wbif.rd_addr_i     = rd;
    wbif.reg_write_i   = rw;
    wbif.wb_sel_i      = sel;
    wbif.load_funct3_i = f3;
    wbif.flush_i       = fl;
    wbif.stall_i       = st;
    if (v && !fl && !st) begin
      exp_instret++;
      if (rw && rd != 5'd0 && !traps(sel, f3, alu)) begin
        e.rd   = rd;
        e.data = model(sel, alu, pc4, f3, m);
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n, input logic [31:0] m);
    for (int i = 0; i < n; i++)
      drive(0, '0, '0, '0, 0, 2'b00, 3'b000, m, 0, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      idle(1, '0);
      k++;
    end
    idle(3, '0);
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && wbif.rf_we_o && !wbif.stall_i) begin
      wr_count++;
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("waddr", 64'(wbif.rf_waddr_o), 64'(e.rd));
        check("wdata", 64'(wbif.rf_wdata_o), 64'(e.data));
      end
    end
    if (!reset && wbif.trap_o) trap_count++;
  end

  initial begin
    int wc;
    int tc;
    reset = 1'b1;
    wbif.in_valid_i    = 0;
    wbif.alu_result_i  = '0;
    wbif.pc_plus4_i    = '0;
    wbif.rd_addr_i     = '0;
    wbif.reg_write_i   = 0;
    wbif.wb_sel_i      = '0;
    wbif.load_funct3_i = '0;
    wbif.data_read_i   = '0;
    wbif.stall_i       = 0;
    wbif.flush_i       = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", 64'(wbif.rf_we_o), 64'd0);
    check("rst_waddr", 64'(wbif.rf_waddr_o), 64'd0);
    check("rst_wdata", 64'(wbif.rf_wdata_o), 64'd0);
    check("rst_fwdv", 64'(wbif.fwd_valid_o), 64'd0);
    check("rst_fwdd", wbif.fwd_data_o, 64'd0);
    check("rst_trap", 64'(wbif.trap_o), 64'd0);
    check("rst_instret", 64'(wbif.instret_o), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    drive(1, 32'h1234, '0, 5'd5, 1, 2'b00, 3'b000, '0, 0, 0);
    idle(1, '0);
    @(negedge clk);
    check("fwd_s1_v", 64'(wbif.fwd_valid_o[0]), 64'd1);
    check("fwd_s1_rd", 64'(wbif.fwd_rd_o[4:0]), 64'd5);
    check("fwd_s1_d", 64'(wbif.fwd_data_o[31:0]), 64'h1234);
    idle(1, '0);
    @(negedge clk);
    check("n2_we", 64'(wbif.rf_we_o), 64'd1);
    check("fwd_s2_v", 64'(wbif.fwd_valid_o[1]), 64'd1);
    check("fwd_s2_d", 64'(wbif.fwd_data_o[63:32]), 64'h1234);
    drain();

    drive(1, 32'h3, '0, 5'd10, 1, 2'b01, 3'b000, 32'h8000_0000, 0, 0);
    drive(1, 32'h3, '0, 5'd11, 1, 2'b01, 3'b100, 32'h8000_0000, 0, 0);
    drive(1, 32'h2, '0, 5'd12, 1, 2'b01, 3'b101, 32'hBEEF_0000, 0, 0);
    drive(1, 32'h0, '0, 5'd14, 1, 2'b01, 3'b001, 32'h0000_8001, 0, 0);
    drive(1, 32'h1, '0, 5'd15, 1, 2'b01, 3'b100, 32'h0000_A500, 0, 0);
    drive(1, 32'h0, '0, 5'd16, 1, 2'b01, 3'b010, 32'h1357_9BDF, 0, 0);
    drive(1, 32'h77, 32'h104, 5'd1, 1, 2'b10, 3'b000, '0, 0, 0);
    drive(1, 32'h55, 32'h108, 5'd2, 1, 2'b11, 3'b000, '0, 0, 0);
    drive(1, 32'h99, '0, 5'd6, 0, 2'b00, 3'b000, '0, 0, 0);
    drain();

    drive(1, 32'h0, '0, 5'd9, 1, 2'b01, 3'b010, 32'h1234_5678, 0, 0);
    wc = wr_count;
    drive(0, '0, '0, '0, 0, 2'b00, 3'b000, 32'hDEAD_0000, 0, 1);
    drive(0, '0, '0, '0, 0, 2'b00, 3'b000, 32'hDEAD_0000, 0, 1);
    drive(0, '0, '0, '0, 0, 2'b00, 3'b000, 32'hDEAD_0000, 0, 1);
    @(negedge clk);
    check("stall_nowr", 64'(wr_count - wc), 64'd0);
    drain();

    drive(1, 32'h44, '0, 5'd4, 1, 2'b00, 3'b000, '0, 0, 0);
    idle(1, '0);
    wc = wr_count;
    drive(1, 32'h77, '0, 5'd7, 1, 2'b00, 3'b000, '0, 1, 0);
    drain();
    check("flush_prior_wr", 64'(wr_count - wc), 64'd1);
    check("flush_instret", 64'(wbif.instret_o), 64'(exp_instret));

    tc = trap_count;
    drive(1, 32'h2, '0, 5'd13, 1, 2'b01, 3'b010, 32'hCAFE_F00D, 0, 0);
    drain();
`ifdef WB_MISALIGN_TRAP_EN
    check("trap_pulse", 64'(trap_count - tc), 64'd1);
    check("trap_addr", 64'(wbif.trap_addr_o), 64'h2);
`else
    check("trap_none", 64'(trap_count - tc), 64'd0);
    check("trap_addr0", 64'(wbif.trap_addr_o), 64'h0);
`endif
    check("instret", 64'(wbif.instret_o), 64'(exp_instret));

    @(negedge clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instret_q;
    drive(1, 32'hAA, '0, 5'd0, 1, 2'b00, 3'b000, '0, 0, 0);
    drive(1, 32'hBB, '0, 5'd3, 1, 2'b00, 3'b000, '0, 0, 0);
    drain();
    check("instret_wrap", 64'(wbif.instret_o), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
